mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage. Registers the EX→MEM bus under the common stall vector.
- Takes the data SRAM read data, which returns one cycle after the address is issued in EX. Aligns and extends load data for lb/lbu/lh/lhu/lw.
- Drives the MEM→WB bus and the MEM forwarding port (wreg/waddr/wdata) used by ID bypass logic.
- Holds SRAM read data across stalls so a stalled load keeps correct data.

Parameters:
- none. Widths come from defines.vh: EX_TO_MEM_WD=79, MEM_TO_WB_WD=70, StallBus=6.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  stall vector; bit3 = MEM register hold, bit4 = WB register hold; Stop=1
- ex_to_mem_bus  in  79  {ld_op[2:0] 78:76, pc 75:44, data_ram_en 43, data_ram_wen 42:39, sel_rf_res 38, rf_we 37, rf_waddr 36:32, ex_result 31:0}
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the EX request
- mem_to_wb_bus  out  70  {pc 69:38, rf_we 37, rf_waddr 36:32, rf_wdata 31:0}
- mem_wreg  out  1  forwarding write enable (equals bus rf_we)
- mem_waddr  out  5  forwarding destination
- mem_wdata  out  32  forwarding data (equals bus rf_wdata)
- mem_adel  out  1  misaligned load flag (lh/lhu with addr[0]=1, or lw with addr[1:0]≠0)

Behaviour:
- Pipeline register ex_to_mem_bus_r, updated on posedge clk, in priority order:
  - rst → all zeros.
  - stall[3]=Stop and stall[4]=NoStop → zeros (bubble).
  - stall[3]=NoStop → load ex_to_mem_bus.
  - otherwise (stall[3]=Stop, stall[4]=Stop) → hold.
- rdata capture:
  - `rd_valid_r` flag and `rd_hold_r` 32-bit register, both reset to 0.
  - The cycle after a new load enters MEM, with stall[4]=Stop: latch data_sram_rdata into rd_hold_r and set rd_valid_r=1.
  - rd_valid_r clears whenever the MEM register loads or bubbles.
  - Effective rdata = rd_valid_r ? rd_hold_r : data_sram_rdata.
- Load align, keyed on ld_op and addr=ex_result[1:0]:
  - LW (000): the word.
  - LB (001) / LBU (010): byte at addr, sign- or zero-extended. Byte 0 = bits 7:0 (little endian).
  - LH (011) / LHU (100): halfword at addr[1] (0 → 15:0, 1 → 31:16), sign- or zero-extended.
  - Other ld_op values are treated as LW.
- Result select:
  - rf_wdata = load-aligned data when sel_rf_res=1, data_ram_en=1 and data_ram_wen=0.
  - Else rf_wdata = ex_result.
  - Stores pass ex_result; they do not write the regfile because rf_we=0 from ID.
- mem_adel:
  - Combinational. Asserted only on loads with a misaligned address.
  - When asserted, rf_we on the bus and the forwarding port is forced to 0.
  - pc passes unchanged.
- Reset values: mem_to_wb_bus=0, mem_wreg=0, mem_waddr=0, mem_wdata=0, mem_adel=0 (all derive from the zeroed register).
- Latency: one register stage. Outputs are combinational from the register, effective rdata and ld_op.
- Bubbles look like no-ops: rf_we=0, pc=0.
- rst during a stall clears both the register and the hold flag in the same edge.
- Stall with an empty (bubble) register: hold logic is inert because data_ram_en=0.

Decomposition:
- defines.vh gains:
  - EX_TO_MEM_WD=79, MEM_TO_WB_WD=70
  - LD_W=3'b000, LD_B=3'b001, LD_BU=3'b010, LD_H=3'b011, LD_HU=3'b100
  - The existing Stop/NoStop and StallBus.
- EX must be extended to drive ld_op into bits 78:76.
- One combinational sub-module, mem_load_align: inputs ld_op, addr[1:0], rdata; outputs wdata and misalign.

Test Plan:
1. LB, addr low bits=2'b11, rdata=32'h80FF_1234, stall=0 → rf_wdata=32'hFFFF_FF80, rf_we=1 one cycle after the bus is presented.
2. LHU, addr=...2, rdata=32'h8001_0000 → rf_wdata=32'h0000_8001. LH, same inputs → 32'hFFFF_8001.
3. LW, addr=...1 → mem_adel=1, mem_wreg=0, bus rf_we=0. Same with addr=...0 → mem_adel=0, wdata=rdata.
4. LW load enters MEM with rdata=32'hDEAD_BEEF; stall=6'b011111 for 3 cycles while rdata changes to 32'h0 → mem_wdata stays 32'hDEAD_BEEF throughout. After release, WB receives DEAD_BEEF.
5. stall[3]=1, stall[4]=0 → next cycle the bus is all zeros (bubble). stall[3]=1, stall[4]=1 → bus held unchanged.
6. Non-load ALU op, ex_result=32'h1234_5678, rf_we=1, waddr=5'd9 → mem_wreg=1, mem_waddr=9, mem_wdata=32'h1234_5678. Assert rst mid-stream → all outputs 0 on the next edge.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, stall encoding, load ops and EX->MEM bus layout
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int STALL_BUS    = 6;
  localparam int STALL_MEM    = 3;
  localparam int STALL_WB     = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } ld_op_e;

  typedef struct packed {
    logic [2:0]  ld_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - little-endian load alignment, extension and misalignment detect
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Unknown ld_op encodings fall through to word semantics.
  always_comb begin
    wdata_o    = rdata_i;
    misalign_o = (addr_i != 2'b00);
    case (ld_op_e'(ld_op_i))
      LD_B: begin
        wdata_o    = {{24{byte_sel[7]}}, byte_sel};
        misalign_o = 1'b0;
      end
      LD_BU: begin
        wdata_o    = {24'h0, byte_sel};
        misalign_o = 1'b0;
      end
      LD_H: begin
        wdata_o    = {{16{half_sel[15]}}, half_sel};
        misalign_o = addr_i[0];
      end
      LD_HU: begin
        wdata_o    = {16'h0, half_sel};
        misalign_o = addr_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline register, stall-safe SRAM read capture and load writeback
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    mem_wreg,
  output logic [4:0]              mem_waddr,
  output logic [31:0]             mem_wdata,
  output logic                    mem_adel
);

  ex_to_mem_t  mem_q, mem_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_hold_q, rd_hold_d;

  logic        is_load;
  logic [31:0] rdata_eff;
  logic [31:0] align_wdata;
  logic        misalign;
  logic [31:0] rf_wdata;
  logic        rf_we_eff;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[2:0]};
  assign is_load      = mem_q.data_ram_en && (mem_q.data_ram_wen == 4'b0000) && mem_q.sel_rf_res;

  // SRAM data is only valid for one cycle; a held load keeps its own copy.
  always_comb begin
    mem_d      = mem_q;
    rd_valid_d = rd_valid_q;
    rd_hold_d  = rd_hold_q;
    if (stall[STALL_MEM] == NO_STOP) begin
      mem_d      = ex_to_mem_t'(ex_to_mem_bus);
      rd_valid_d = 1'b0;
    end else if (stall[STALL_WB] == NO_STOP) begin
      mem_d      = '0;
      rd_valid_d = 1'b0;
    end else if (is_load && !rd_valid_q) begin
      rd_hold_d  = data_sram_rdata;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_valid_q <= rd_valid_d;
      rd_hold_q  <= rd_hold_d;
    end
  end

  assign rdata_eff = rd_valid_q ? rd_hold_q : data_sram_rdata;

  mem_load_align u_align (
    .ld_op_i    (mem_q.ld_op),
    .addr_i     (mem_q.ex_result[1:0]),
    .rdata_i    (rdata_eff),
    .wdata_o    (align_wdata),
    .misalign_o (misalign)
  );

  assign mem_adel  = is_load && misalign;
  assign rf_wdata  = is_load ? align_wdata : mem_q.ex_result;
  assign rf_we_eff = mem_q.rf_we && !mem_adel;

  assign mem_to_wb_bus = {mem_q.pc, rf_we_eff, mem_q.rf_waddr, rf_wdata};
  assign mem_wreg      = rf_we_eff;
  assign mem_waddr     = mem_q.rf_waddr;
  assign mem_wdata     = rf_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed load/stall/reset vectors
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [78:0] ex_bus;
  logic [31:0] rdata;
  logic [69:0] wb_bus;
  logic        wreg;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        adel;

  int cyc;
  int total_cnt;
  int pass_cnt;

  typedef struct {
    string       name;
    int          due;
    logic [69:0] bus;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_bus),
    .data_sram_rdata (rdata),
    .mem_to_wb_bus   (wb_bus),
    .mem_wreg        (wreg),
    .mem_waddr       (waddr),
    .mem_wdata       (wdata),
    .mem_adel        (adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [78:0] exb(logic [2:0] op, logic [31:0] pc, logic en, logic [3:0] wen,
                                      logic sel, logic we, logic [4:0] wa, logic [31:0] res);
    return {op, pc, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [69:0] wbb(logic [31:0] pc, logic we, logic [4:0] wa, logic [31:0] wd);
    return {pc, we, wa, wd};
  endfunction

  task automatic step(input string name, input logic r, input logic [5:0] st, input logic [78:0] b,
                      input logic [31:0] rd, input logic [69:0] ebus, input logic eadel);
    exp_t e;
    @(negedge clk);
    #1;
    rst    = r;
    stall  = st;
    ex_bus = b;
    rdata  = rd;
    e.name  = name;
    e.due   = cyc + 1;
    e.bus   = ebus;
    e.wreg  = ebus[37];
    e.waddr = ebus[36:32];
    e.wdata = ebus[31:0];
    e.adel  = eadel;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (e.due != cyc) begin
        $display("FAIL %s: output not observed at cycle %0d (now %0d)", e.name, e.due, cyc);
      end else if ({wb_bus, wreg, waddr, wdata, adel} !== {e.bus, e.wreg, e.waddr, e.wdata, e.adel}) begin
        $display("FAIL %s: got bus=%h wreg=%b waddr=%0d wdata=%h adel=%b, expected bus=%h wreg=%b waddr=%0d wdata=%h adel=%b",
                 e.name, wb_bus, wreg, waddr, wdata, adel, e.bus, e.wreg, e.waddr, e.wdata, e.adel);
      end else begin
        pass_cnt++;
      end
    end
  end

  initial begin
    cyc = 0; total_cnt = 0; pass_cnt = 0;
    rst = 1'b1; stall = 6'b0; ex_bus = '0; rdata = '0;

    step("reset", 1'b1, 6'b0, exb(3'b001, 32'h100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h1003), 32'h0, '0, 1'b0);

    step("lb_addr3", 1'b0, 6'b0, exb(3'b001, 32'h100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h1003),
         32'h80FF_1234, wbb(32'h100, 1'b1, 5'd3, 32'hFFFF_FF80), 1'b0);
    step("lhu_addr2", 1'b0, 6'b0, exb(3'b100, 32'h104, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h2002),
         32'h8001_0000, wbb(32'h104, 1'b1, 5'd4, 32'h0000_8001), 1'b0);
    step("lh_addr2", 1'b0, 6'b0, exb(3'b011, 32'h108, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5, 32'h2002),
         32'h8001_0000, wbb(32'h108, 1'b1, 5'd5, 32'hFFFF_8001), 1'b0);
    step("lw_mis", 1'b0, 6'b0, exb(3'b000, 32'h10C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h3001),
         32'h1122_3344, wbb(32'h10C, 1'b0, 5'd6, 32'h1122_3344), 1'b1);
    step("lw_ok", 1'b0, 6'b0, exb(3'b000, 32'h110, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h3000),
         32'h1122_3344, wbb(32'h110, 1'b1, 5'd6, 32'h1122_3344), 1'b0);
    step("lb_addr0", 1'b0, 6'b0, exb(3'b001, 32'h114, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h3000),
         32'h1122_B344, wbb(32'h114, 1'b1, 5'd7, 32'h0000_0044), 1'b0);
    step("lbu_addr1", 1'b0, 6'b0, exb(3'b010, 32'h118, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h3001),
         32'h1122_B344, wbb(32'h118, 1'b1, 5'd8, 32'h0000_00B3), 1'b0);
    step("lb_addr1", 1'b0, 6'b0, exb(3'b001, 32'h11C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h3001),
         32'h1122_B344, wbb(32'h11C, 1'b1, 5'd8, 32'hFFFF_FFB3), 1'b0);
    step("lh_mis", 1'b0, 6'b0, exb(3'b011, 32'h120, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h3001),
         32'h1122_B344, wbb(32'h120, 1'b0, 5'd8, 32'hFFFF_B344), 1'b1);
    step("lhu_mis", 1'b0, 6'b0, exb(3'b100, 32'h124, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h3003),
         32'h1122_B344, wbb(32'h124, 1'b0, 5'd9, 32'h0000_1122), 1'b1);
    step("store", 1'b0, 6'b0, exb(3'b000, 32'h128, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h4001),
         32'h1122_B344, wbb(32'h128, 1'b0, 5'd0, 32'h0000_4001), 1'b0);
    step("alu", 1'b0, 6'b0, exb(3'b000, 32'h200, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h1234_5678),
         32'h1122_B344, wbb(32'h200, 1'b1, 5'd9, 32'h1234_5678), 1'b0);
    step("sel_no_ram", 1'b0, 6'b0, exb(3'b001, 32'h204, 1'b0, 4'h0, 1'b1, 1'b1, 5'd10, 32'h0000_0055),
         32'h1122_B344, wbb(32'h204, 1'b1, 5'd10, 32'h0000_0055), 1'b0);

    step("hold_enter", 1'b0, 6'b0, exb(3'b000, 32'h300, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h5000),
         32'hDEAD_BEEF, wbb(32'h300, 1'b1, 5'd7, 32'hDEAD_BEEF), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("hold_stall%0d", i), 1'b0, 6'b011111,
           exb(3'b000, 32'h304, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, 32'h1111),
           (i == 0) ? 32'hDEAD_BEEF : 32'h0, wbb(32'h300, 1'b1, 5'd7, 32'hDEAD_BEEF), 1'b0);
    end
    step("hold_release", 1'b0, 6'b0, exb(3'b000, 32'h304, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, 32'h1111),
         32'h0, wbb(32'h304, 1'b1, 5'd1, 32'h1111), 1'b0);

    step("pre_bubble", 1'b0, 6'b0, exb(3'b000, 32'h400, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10, 32'hAAAA),
         32'h0, wbb(32'h400, 1'b1, 5'd10, 32'hAAAA), 1'b0);
    step("bubble", 1'b0, 6'b001000, exb(3'b000, 32'h404, 1'b0, 4'h0, 1'b0, 1'b1, 5'd11, 32'hBBBB),
         32'h0, '0, 1'b0);
    step("after_bubble", 1'b0, 6'b0, exb(3'b000, 32'h404, 1'b0, 4'h0, 1'b0, 1'b1, 5'd11, 32'hBBBB),
         32'h0, wbb(32'h404, 1'b1, 5'd11, 32'hBBBB), 1'b0);
    for (int i = 0; i < 2; i++) begin
      step($sformatf("reg_hold%0d", i), 1'b0, 6'b011000,
           exb(3'b000, 32'h408, 1'b0, 4'h0, 1'b0, 1'b1, 5'd12, 32'hCCCC),
           32'h0, wbb(32'h404, 1'b1, 5'd11, 32'hBBBB), 1'b0);
    end
    step("rst_in_stall", 1'b1, 6'b011000, exb(3'b000, 32'h408, 1'b0, 4'h0, 1'b0, 1'b1, 5'd12, 32'hCCCC),
         32'h0, '0, 1'b0);

    step("load2", 1'b0, 6'b0, exb(3'b000, 32'h500, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h6000),
         32'hCAFE_F00D, wbb(32'h500, 1'b1, 5'd13, 32'hCAFE_F00D), 1'b0);
    step("load2_hold", 1'b0, 6'b011111, exb(3'b000, 32'h504, 1'b1, 4'h0, 1'b1, 1'b1, 5'd14, 32'h6004),
         32'hCAFE_F00D, wbb(32'h500, 1'b1, 5'd13, 32'hCAFE_F00D), 1'b0);
    step("rst_load_hold", 1'b1, 6'b011111, exb(3'b000, 32'h504, 1'b1, 4'h0, 1'b1, 1'b1, 5'd14, 32'h6004),
         32'h0, '0, 1'b0);
    step("load3", 1'b0, 6'b0, exb(3'b000, 32'h504, 1'b1, 4'h0, 1'b1, 1'b1, 5'd14, 32'h6004),
         32'h0102_0304, wbb(32'h504, 1'b1, 5'd14, 32'h0102_0304), 1'b0);

    repeat (3) @(negedge clk);
    #2;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total_cnt++;
      $display("FAIL %s: expectation never checked (due %0d, now %0d)", e.name, e.due, cyc);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
